// File: rtl/dma_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dma_sched
//  Purpose  : Two-requester DMA job scheduler. Each requester owns a
//             QDEPTH-entry command queue; an IDLE/RUN/DONE controller grants
//             requesters round-robin, drives one job at a time to the DMA
//             engine and reports completion.
//  Options  : DMA_SCHED_TIMEOUT_EN - adds a RUN watchdog of TIMEOUT_CYC
//             cycles that ends a stuck job with done_err = 1.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_sched #(
   parameter int QDEPTH      = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_src,
   input  logic [31:0] req0_dst,
   input  logic [31:0] req0_len,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_src,
   input  logic [31:0] req1_dst,
   input  logic [31:0] req1_len,
   output logic        DMAEN,
   output logic [31:0] DMASRC,
   output logic [31:0] DMADST,
   output logic [31:0] DMALEN,
   input  logic        DMA_interrupt,
   output logic        dma_int_clr,
   output logic        done_valid,
   output logic        done_id,
   output logic        done_err,
   output logic        busy
);

   localparam int c_AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int c_CW = c_AW + 1;

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_RUN  = 2'd1;
   localparam logic [1:0] c_S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;

   logic [1:0]        w_valid;
   logic [1:0]        w_ready;
   logic [1:0]        w_elig;
   logic [1:0]        w_pop;
   logic [1:0][95:0]  w_din;
   logic [1:0][95:0]  w_head;

   logic              w_grant_any;
   logic              w_grant_id;
   logic [95:0]       w_sel;

   logic [31:0]       r_src;
   logic [31:0]       r_dst;
   logic [31:0]       r_len;
   logic              r_id;
   logic              r_zero;
   logic              r_last;

   assign w_valid = {req1_valid, req0_valid};
   assign w_din[0] = {req0_src, req0_dst, req0_len};
   assign w_din[1] = {req1_src, req1_dst, req1_len};

   // Ready reflects only the stored count: a full queue is not-ready even
   // in the cycle it is popped.
   assign req0_ready = w_ready[0] & ~rst;
   assign req1_ready = w_ready[1] & ~rst;

   // ------------------------------------------------------------------------
   // Per-requester command queues
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_queue
         logic [95:0]      r_mem [QDEPTH];
         logic [c_CW-1:0]  r_wp;
         logic [c_CW-1:0]  r_rp;
         logic             r_push_d;
         logic [c_CW-1:0]  w_cnt;
         logic             w_push;

         assign w_cnt        = r_wp - r_rp;
         assign w_ready[gi]  = (w_cnt != c_CW'(QDEPTH));
         assign w_push       = w_valid[gi] & w_ready[gi];
         // An entry written on the previous edge is not yet grantable.
         assign w_elig[gi]   = (w_cnt > {{(c_CW-1){1'b0}}, r_push_d});
         assign w_head[gi]   = r_mem[r_rp[c_AW-1:0]];

         // Queue pointers and last-cycle push marker
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_wp     <= '0;
               r_rp     <= '0;
               r_push_d <= 1'b0;
            end else begin
               r_push_d <= w_push;
               if (w_push) begin
                  r_wp <= r_wp + c_CW'(1);
               end
               if (w_pop[gi]) begin
                  r_rp <= r_rp + c_CW'(1);
               end
            end
         end

         // Queue storage write
         always_ff @(posedge clk) begin
            if (w_push) begin
               r_mem[r_wp[c_AW-1:0]] <= w_din[gi];
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Round-robin grant, only from IDLE and only with the interrupt low
   // ------------------------------------------------------------------------
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_id  = 1'b0;
      if ((r_state == c_S_IDLE) && !DMA_interrupt) begin
         if (w_elig[0] && w_elig[1]) begin
            w_grant_any = 1'b1;
            w_grant_id  = ~r_last;
         end else if (w_elig[0]) begin
            w_grant_any = 1'b1;
            w_grant_id  = 1'b0;
         end else if (w_elig[1]) begin
            w_grant_any = 1'b1;
            w_grant_id  = 1'b1;
         end
      end
   end

   assign w_pop[0] = w_grant_any & ~w_grant_id;
   assign w_pop[1] = w_grant_any &  w_grant_id;
   assign w_sel    = w_head[w_grant_id];

   // Job latch: capture the granted head entry; r_last starts at 1 so
   // requester 0 wins the first contention
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_len  <= '0;
         r_id   <= 1'b0;
         r_zero <= 1'b0;
         r_last <= 1'b1;
      end else if (w_grant_any) begin
         r_src  <= w_sel[95:64];
         r_dst  <= w_sel[63:32];
         r_len  <= w_sel[31:0];
         r_id   <= w_grant_id;
         r_zero <= (w_sel[31:0] == 32'd0);
         r_last <= w_grant_id;
      end
   end

   // ------------------------------------------------------------------------
   // Optional RUN watchdog
   // ------------------------------------------------------------------------
`ifdef DMA_SCHED_TIMEOUT_EN
   localparam int c_TW = $clog2(TIMEOUT_CYC) + 1;

   logic [c_TW-1:0] r_wdog;
   logic            r_err;
   logic            w_wdog_hit;

   assign w_wdog_hit = (r_state == c_S_RUN) && (r_wdog == c_TW'(TIMEOUT_CYC - 1));

   // Watchdog counts RUN cycles; an interrupt at the limit still wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else if (w_grant_any) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else if (r_state == c_S_RUN) begin
         r_wdog <= r_wdog + c_TW'(1);
         if (w_wdog_hit && !DMA_interrupt) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   localparam int c_unused_timeout = TIMEOUT_CYC;
`endif

   // ------------------------------------------------------------------------
   // Controller FSM
   // ------------------------------------------------------------------------
   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: zero-length jobs skip RUN entirely
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (w_grant_any) begin
               w_state_nxt = (w_sel[31:0] == 32'd0) ? c_S_DONE : c_S_RUN;
            end
         end
         c_S_RUN: begin
            if (DMA_interrupt) begin
               w_state_nxt = c_S_DONE;
            end
`ifdef DMA_SCHED_TIMEOUT_EN
            else if (w_wdog_hit) begin
               w_state_nxt = c_S_DONE;
            end
`endif
         end
         c_S_DONE: w_state_nxt = c_S_IDLE;
         default:  w_state_nxt = c_S_IDLE;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      DMAEN       = (r_state == c_S_RUN);
      done_valid  = (r_state == c_S_DONE);
      dma_int_clr = (r_state == c_S_DONE) && !r_zero;
      busy        = (r_state != c_S_IDLE);
`ifdef DMA_SCHED_TIMEOUT_EN
      done_err    = (r_state == c_S_DONE) && r_err;
`else
      done_err    = 1'b0;
`endif
   end

   assign DMASRC  = r_src;
   assign DMADST  = r_dst;
   assign DMALEN  = r_len;
   assign done_id = r_id;

endmodule
`default_nettype wire

// File: tb/tb_dma_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_sched
//  Purpose  : Self-checking bench for dma_sched: directed vector table,
//             hand-written corner sequences and a randomized run against a
//             queue-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_sched;

   localparam int QD  = 2;
   localparam int TOC = 8;
`ifdef DMA_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r0v = 1'b0, r1v = 1'b0, intr = 1'b0;
   logic [31:0] r0s = '0, r0d = '0, r0l = '0, r1s = '0, r1d = '0, r1l = '0;
   logic        r0rdy, r1rdy, en, clr, dv, did, derr, bsy;
   logic [31:0] osrc, odst, olen;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dma_sched #(.QDEPTH(QD), .TIMEOUT_CYC(TOC)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(r0rdy),
      .req0_src(r0s), .req0_dst(r0d), .req0_len(r0l),
      .req1_valid(r1v), .req1_ready(r1rdy),
      .req1_src(r1s), .req1_dst(r1d), .req1_len(r1l),
      .DMAEN(en), .DMASRC(osrc), .DMADST(odst), .DMALEN(olen),
      .DMA_interrupt(intr), .dma_int_clr(clr),
      .done_valid(dv), .done_id(did), .done_err(derr), .busy(bsy)
   );

   task automatic chk1(input string name, input logic act, input logic want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", name, act, want);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; r0v = 1'b0; r1v = 1'b0; intr = 1'b0;
      step();
      chk1("rst_en", en, 1'b0);     chk32("rst_src", osrc, 32'h0);
      chk32("rst_dst", odst, 32'h0); chk32("rst_len", olen, 32'h0);
      chk1("rst_clr", clr, 1'b0);   chk1("rst_dv", dv, 1'b0);
      chk1("rst_id", did, 1'b0);    chk1("rst_err", derr, 1'b0);
      chk1("rst_busy", bsy, 1'b0);
      step();
      rst = 1'b0;
      #1;
      chk1("rst_rdy0", r0rdy, 1'b1);
      chk1("rst_rdy1", r1rdy, 1'b1);
   endtask

   // ------------------------------------------------------------------------
   // Directed vector table: one row per clock cycle
   // ------------------------------------------------------------------------
   typedef struct {
      logic        v0, v1;
      logic [31:0] src, dst, len;
      logic        it;
      logic        en;
      logic [31:0] esrc;
      logic        dv, id, clr, bz;
   } vec_t;

   vec_t tbl [22];

   task automatic setv(input int i, input logic v0, input logic v1,
                       input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                       input logic it, input logic e, input logic [31:0] es,
                       input logic v, input logic id, input logic c, input logic b);
      tbl[i] = '{v0, v1, s, d, l, it, e, es, v, id, c, b};
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: FIFOs as queues tagged with the push edge number
   // ------------------------------------------------------------------------
   typedef struct {
      logic [31:0] src, dst, len;
      int          e;
   } job_t;

   job_t        mq0[$], mq1[$];
   int          m_phase;      // 0 idle, 1 transferring, 2 completion cycle
   int          m_runs, m_edge;
   bit          m_last, m_id, m_zero, m_err;
   logic [31:0] m_src, m_dst, m_len;

   task automatic model_reset();
      mq0.delete(); mq1.delete();
      m_phase = 0; m_runs = 0; m_edge = 0;
      m_last = 1'b1; m_id = 1'b0; m_zero = 1'b0; m_err = 1'b0;
      m_src = '0; m_dst = '0; m_len = '0;
   endtask

   task automatic model_check();
      chk1("m_en", en, m_phase == 1);
      chk32("m_src", osrc, m_src);
      chk32("m_dst", odst, m_dst);
      chk32("m_len", olen, m_len);
      chk1("m_dv", dv, m_phase == 2);
      if (m_phase == 2) chk1("m_id", did, m_id);
      chk1("m_err", derr, (m_phase == 2) && m_err);
      chk1("m_clr", clr, (m_phase == 2) && !m_zero);
      chk1("m_busy", bsy, m_phase != 0);
      chk1("m_rdy0", r0rdy, mq0.size() < QD);
      chk1("m_rdy1", r1rdy, mq1.size() < QD);
   endtask

   task automatic model_edge();
      bit   rd0, rd1, el0, el1, id;
      job_t j;
      rd0 = mq0.size() < QD;
      rd1 = mq1.size() < QD;
      case (m_phase)
         0: begin
            if (!intr) begin
               el0 = (mq0.size() > 0) && (mq0[0].e <= m_edge - 2);
               el1 = (mq1.size() > 0) && (mq1[0].e <= m_edge - 2);
               if (el0 || el1) begin
                  id = (el0 && el1) ? !m_last : !el0;
                  j  = id ? mq1.pop_front() : mq0.pop_front();
                  m_src = j.src; m_dst = j.dst; m_len = j.len;
                  m_id = id; m_last = id; m_zero = (j.len == 0);
                  m_err = 1'b0; m_runs = 0;
                  m_phase = m_zero ? 2 : 1;
               end
            end
         end
         1: begin
            m_runs++;
            if (intr) begin
               m_phase = 2; m_err = 1'b0;
            end else if (TO_EN && m_runs == TOC) begin
               m_phase = 2; m_err = 1'b1;
            end
         end
         default: m_phase = 0;
      endcase
      if (r0v && rd0) mq0.push_back('{r0s, r0d, r0l, m_edge});
      if (r1v && rd1) mq1.push_back('{r1s, r1d, r1l, m_edge});
      m_edge++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rr_src [4];
      logic        rr_id  [4];
      int          w, runs;
      bit          seen_en, seen_dv;

      // ---------------- Directed table: single job, zero-length, stale irq
      setv( 0,1'b1,1'b0,32'h1000,32'h2000,32'd16,1'b0, 1'b0,32'h0,   1'b0,1'b0,1'b0,1'b0);
      setv( 1,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h0,   1'b0,1'b0,1'b0,1'b0);
      setv( 2,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h0,   1'b0,1'b0,1'b0,1'b0);
      for (int i = 3; i < 8; i++)
         setv(i,1'b0,1'b0,32'h0, 32'h0,   32'd0, 1'b0, 1'b1,32'h1000,1'b0,1'b0,1'b0,1'b1);
      setv( 8,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b1, 1'b1,32'h1000,1'b0,1'b0,1'b0,1'b1);
      setv( 9,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b1, 1'b0,32'h1000,1'b1,1'b0,1'b1,1'b1);
      setv(10,1'b0,1'b1,32'h3000,32'h3100,32'd0, 1'b0, 1'b0,32'h1000,1'b0,1'b0,1'b0,1'b0);
      setv(11,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h1000,1'b0,1'b0,1'b0,1'b0);
      setv(12,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h1000,1'b0,1'b0,1'b0,1'b0);
      setv(13,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h3000,1'b1,1'b1,1'b0,1'b1);
      setv(14,1'b1,1'b0,32'h4000,32'h5000,32'd4, 1'b1, 1'b0,32'h3000,1'b0,1'b0,1'b0,1'b0);
      for (int i = 15; i < 18; i++)
         setv(i,1'b0,1'b0,32'h0, 32'h0,   32'd0, 1'b1, 1'b0,32'h3000,1'b0,1'b0,1'b0,1'b0);
      setv(18,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h3000,1'b0,1'b0,1'b0,1'b0);
      setv(19,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b1, 1'b1,32'h4000,1'b0,1'b0,1'b0,1'b1);
      setv(20,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h4000,1'b1,1'b0,1'b1,1'b1);
      setv(21,1'b0,1'b0,32'h0,   32'h0,   32'd0, 1'b0, 1'b0,32'h4000,1'b0,1'b0,1'b0,1'b0);

      do_reset();
      for (int i = 0; i < 22; i++) begin
         r0v = tbl[i].v0; r1v = tbl[i].v1; intr = tbl[i].it;
         r0s = tbl[i].src; r0d = tbl[i].dst; r0l = tbl[i].len;
         r1s = tbl[i].src; r1d = tbl[i].dst; r1l = tbl[i].len;
         @(negedge clk);
         chk1($sformatf("tbl%0d_en", i), en, tbl[i].en);
         chk32($sformatf("tbl%0d_src", i), osrc, tbl[i].esrc);
         chk1($sformatf("tbl%0d_dv", i), dv, tbl[i].dv);
         if (tbl[i].dv) chk1($sformatf("tbl%0d_id", i), did, tbl[i].id);
         chk1($sformatf("tbl%0d_clr", i), clr, tbl[i].clr);
         chk1($sformatf("tbl%0d_busy", i), bsy, tbl[i].bz);
         step();
      end
      r0v = 1'b0; r1v = 1'b0; intr = 1'b0;

      // ---------------- Both requesters push two jobs together
      do_reset();
      r0v = 1'b1; r1v = 1'b1; r0l = 32'd8; r1l = 32'd8;
      r0s = 32'hA000; r1s = 32'hB000;
      step();
      r0s = 32'hA100; r1s = 32'hB100;
      chk1("rr_rdy0_one", r0rdy, 1'b1);
      chk1("rr_rdy1_one", r1rdy, 1'b1);
      step();
      r0v = 1'b0; r1v = 1'b0;
      chk1("rr_rdy0_full", r0rdy, 1'b0);
      chk1("rr_rdy1_full", r1rdy, 1'b0);
      rr_src[0] = 32'hA000; rr_src[1] = 32'hB000; rr_src[2] = 32'hA100; rr_src[3] = 32'hB100;
      rr_id[0] = 1'b0; rr_id[1] = 1'b1; rr_id[2] = 1'b0; rr_id[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (!en && w < 20) begin step(); w++; end
         chk1($sformatf("rr%0d_en", k), en, 1'b1);
         chk32($sformatf("rr%0d_src", k), osrc, rr_src[k]);
         intr = 1'b1;
         step();
         chk1($sformatf("rr%0d_dv", k), dv, 1'b1);
         chk1($sformatf("rr%0d_id", k), did, rr_id[k]);
         intr = 1'b0;
         step();
      end

      // ---------------- Watchdog / indefinite wait
      do_reset();
      r0v = 1'b1; r0s = 32'hC000; r0d = 32'hC800; r0l = 32'd5;
      step();
      r0v = 1'b0;
      runs = 0; w = 0;
      while (!dv && w < 60) begin
         if (en) runs++;
         step(); w++;
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      chk32("to_runs", runs, TOC);
      chk1("to_dv", dv, 1'b1);
      chk1("to_err", derr, 1'b1);
      chk1("to_clr", clr, 1'b1);
      step();
      // Interrupt arriving in the limit cycle wins over the timeout
      r0v = 1'b1; r0s = 32'hE000;
      step();
      r0v = 1'b0;
      w = 0;
      while (!en && w < 20) begin step(); w++; end
      for (int k = 1; k < TOC; k++) step();
      chk1("to_last_en", en, 1'b1);
      intr = 1'b1;
      step();
      chk1("to_race_dv", dv, 1'b1);
      chk1("to_race_err", derr, 1'b0);
      intr = 1'b0;
      step();
`else
      chk1("noto_dv", dv, 1'b0);
      chk1("noto_en", en, 1'b1);
      intr = 1'b1;
      step();
      chk1("noto_end_dv", dv, 1'b1);
      chk1("noto_end_err", derr, 1'b0);
      intr = 1'b0;
      step();
`endif

      // ---------------- Reset in the third RUN cycle
      do_reset();
      r0v = 1'b1; r0s = 32'hD000; r0l = 32'd9;
      step();
      r0s = 32'hD100;
      step();
      r0v = 1'b0;
      w = 0;
      while (!en && w < 20) begin step(); w++; end
      step();
      step();
      chk1("mid_pre_en", en, 1'b1);
      rst = 1'b1;
      #1;
      chk1("mid_en", en, 1'b0);
      chk1("mid_dv", dv, 1'b0);
      chk1("mid_busy", bsy, 1'b0);
      chk32("mid_src", osrc, 32'h0);
      step();
      rst = 1'b0;
      seen_en = 1'b0; seen_dv = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         seen_en |= en;
         seen_dv |= dv;
      end
      chk1("mid_after_en", seen_en, 1'b0);
      chk1("mid_after_dv", seen_dv, 1'b0);
      chk1("mid_after_rdy0", r0rdy, 1'b1);

      // ---------------- Randomized run against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
         r0v  = ($urandom_range(0, 2) == 0);
         r1v  = ($urandom_range(0, 2) == 0);
         r0s  = $urandom; r0d = $urandom;
         r1s  = $urandom; r1d = $urandom;
         r0l  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         r1l  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         intr = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         model_check();
         @(posedge clk);
         model_edge();
         #1;
      end
      r0v = 1'b0; r1v = 1'b0; intr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
